// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, entry limits and the row/column to key-code map
// shared by the keypad scanner and the entry accumulator.
package keypad_pkg;

   localparam logic [3:0] KEY_A    = 4'd10;
   localparam logic [3:0] KEY_B    = 4'd11;
   localparam logic [3:0] KEY_C    = 4'd12;
   localparam logic [3:0] KEY_D    = 4'd13;
   localparam logic [3:0] KEY_STAR = 4'd14;
   localparam logic [3:0] KEY_HASH = 4'd15;

   // All sixteen 4-bit codes are real keys, so "no key" needs a fifth bit.
   localparam logic [4:0] KEY_NONE = 5'h10;

   localparam int MAX_DIGITS = 4;

   typedef enum logic {
      ST_RELEASED,
      ST_HELD
   } deb_state_t;

   function automatic logic [3:0] key_map(
      input logic [1:0] row,
      input logic [1:0] col
   );
      logic [3:0] code;
      case ({row, col})
         4'h0: code = 4'd1;
         4'h1: code = 4'd2;
         4'h2: code = 4'd3;
         4'h3: code = KEY_A;
         4'h4: code = 4'd4;
         4'h5: code = 4'd5;
         4'h6: code = 4'd6;
         4'h7: code = KEY_B;
         4'h8: code = 4'd7;
         4'h9: code = 4'd8;
         4'hA: code = 4'd9;
         4'hB: code = KEY_C;
         4'hC: code = KEY_STAR;
         4'hD: code = 4'd0;
         4'hE: code = KEY_HASH;
         default: code = KEY_D;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives one active-low column per slot, synchronises the
// rows, captures a 16-key matrix per scan and debounces it into one strobe
// per clean keypress.
// Ports: clk_100mhz, reset (async, active-high), col_n[3:0] out,
//        row_n[3:0] in, key_strobe out, key_code[3:0] out.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 100000,
   parameter int DEBOUNCE_CNT = 5
) (
   input  logic       clk_100mhz,
   input  logic       reset,
   output logic [3:0] col_n,
   input  logic [3:0] row_n,
   output logic       key_strobe,
   output logic [3:0] key_code
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CNT);

   logic [DW-1:0] div_q;
   logic [1:0]    col_q;
   logic [3:0]    sync1_q;
   logic [3:0]    sync2_q;
   logic [15:0]   mat_q;
   logic [4:0]    prev_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   deb_state_t    state_q;
   deb_state_t    state_d;
   logic          strobe_d;
   logic [3:0]    code_d;

   logic          slot_end;
   logic          scan_end;
   logic [15:0]   mat_full;
   logic [4:0]    hits;
   logic [3:0]    hit_code;
   logic [4:0]    cand;
   logic          stable;

   assign slot_end = (div_q == DIV_LAST);
   assign scan_end = slot_end && (col_q == 2'd3);
   assign col_n    = ~(4'b0001 << col_q);

   always_ff @(posedge clk_100mhz or posedge reset) begin
      if (reset) begin
         div_q   <= '0;
         col_q   <= 2'd0;
         sync1_q <= 4'hF;
         sync2_q <= 4'hF;
         mat_q   <= '0;
      end else begin
         sync1_q <= row_n;
         sync2_q <= sync1_q;
         if (slot_end) begin
            div_q <= '0;
            col_q <= col_q + 2'd1;
            mat_q[{col_q, 2'b00} +: 4] <= ~sync2_q;
         end else begin
            div_q <= div_q + DW'(1);
         end
      end
   end

   // Column 3 is sampled in the same cycle the scan is judged, so its
   // rows come straight from the synchroniser rather than the matrix.
   always_comb begin
      mat_full        = mat_q;
      mat_full[15:12] = ~sync2_q;
      hits            = '0;
      hit_code        = '0;
      for (int i = 0; i < 16; i++) begin
         if (mat_full[i]) begin
            hits     = hits + 5'd1;
            hit_code = key_map(2'(i), 2'(i >> 2));
         end
      end
      cand = (hits == 5'd1) ? {1'b0, hit_code} : KEY_NONE;
   end

   always_comb begin
      if (cand != prev_q) begin
         cnt_d = CW'(1);
      end else if (cnt_q == CNT_MAX) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      stable = (cnt_d == CNT_MAX);
   end

   always_comb begin
      state_d  = state_q;
      strobe_d = 1'b0;
      code_d   = key_code;
      if (scan_end) begin
         unique case (state_q)
            ST_RELEASED: begin
               if (cand != KEY_NONE && stable) begin
                  state_d  = ST_HELD;
                  strobe_d = 1'b1;
                  code_d   = cand[3:0];
               end
            end
            ST_HELD: begin
               if (cand == KEY_NONE && stable) begin
                  state_d = ST_RELEASED;
               end
            end
            default: state_d = ST_RELEASED;
         endcase
      end
   end

   always_ff @(posedge clk_100mhz or posedge reset) begin
      if (reset) begin
         state_q    <= ST_RELEASED;
         prev_q     <= KEY_NONE;
         cnt_q      <= '0;
         key_strobe <= 1'b0;
         key_code   <= 4'd0;
      end else begin
         state_q    <= state_d;
         key_strobe <= strobe_d;
         key_code   <= code_d;
         if (scan_end) begin
            prev_q <= cand;
            cnt_q  <= cnt_d;
         end
      end
   end

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: scans a 4x4 keypad and assembles up to four decimal digits
// into a binary entry committed with '#'; '*' clears the entry.
// Ports: clk_100mhz, reset (async, active-high), col_n/row_n keypad pins,
//        key_strobe/key_code, value, digit_count, entry_value, entry_valid.
// Build option: KEYPAD_BACKSPACE_EN makes 'D' delete the last digit.
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 100000,
   parameter int DEBOUNCE_CNT = 5
) (
   input  logic        clk_100mhz,
   input  logic        reset,
   output logic [3:0]  col_n,
   input  logic [3:0]  row_n,
   output logic        key_strobe,
   output logic [3:0]  key_code,
   output logic [15:0] value,
   output logic [2:0]  digit_count,
   output logic [15:0] entry_value,
   output logic        entry_valid
);

   localparam logic [2:0] DIG_MAX = 3'(MAX_DIGITS);

   logic [13:0] val_q;
   logic [13:0] val_d;
   logic [2:0]  cnt_q;
   logic [2:0]  cnt_d;
   logic [13:0] ent_q;
   logic [13:0] ent_d;
   logic        ev_q;
   logic        ev_d;
   logic        is_digit;

   keypad_scanner #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) u_scanner (
      .clk_100mhz (clk_100mhz),
      .reset      (reset),
      .col_n      (col_n),
      .row_n      (row_n),
      .key_strobe (key_strobe),
      .key_code   (key_code)
   );

   assign is_digit    = (key_code <= 4'd9);
   assign value       = {2'b00, val_q};
   assign digit_count = cnt_q;
   assign entry_value = {2'b00, ent_q};
   assign entry_valid = ev_q;

   always_comb begin
      val_d = val_q;
      cnt_d = cnt_q;
      ent_d = ent_q;
      ev_d  = 1'b0;
      if (key_strobe) begin
         unique case (1'b1)
            is_digit: begin
               if (cnt_q < DIG_MAX) begin
                  val_d = val_q * 14'd10 + {10'd0, key_code};
                  cnt_d = cnt_q + 3'd1;
               end
            end
            (key_code == KEY_STAR): begin
               val_d = '0;
               cnt_d = '0;
            end
            (key_code == KEY_HASH): begin
               if (cnt_q != 3'd0) begin
                  ent_d = val_q;
                  ev_d  = 1'b1;
                  val_d = '0;
                  cnt_d = '0;
               end
            end
`ifdef KEYPAD_BACKSPACE_EN
            (key_code == KEY_D): begin
               if (cnt_q != 3'd0) begin
                  val_d = val_q / 14'd10;
                  cnt_d = cnt_q - 3'd1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_100mhz or posedge reset) begin
      if (reset) begin
         val_q <= '0;
         cnt_q <= '0;
         ent_q <= '0;
         ev_q  <= 1'b0;
      end else begin
         val_q <= val_d;
         cnt_q <= cnt_d;
         ent_q <= ent_d;
         ev_q  <= ev_d;
      end
   end

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: keypad model plus scoreboard for keypad_entry with
// SCAN_DIV = 4 and DEBOUNCE_CNT = 3.
module tb_keypad_entry;

   localparam int SD   = 4;
   localparam int DC   = 3;
   localparam int SCAN = 4 * SD;

   logic        clk_100mhz = 1'b0;
   logic        reset;
   logic [3:0]  col_n;
   logic [3:0]  row_n;
   logic        key_strobe;
   logic [3:0]  key_code;
   logic [15:0] value;
   logic [2:0]  digit_count;
   logic [15:0] entry_value;
   logic        entry_valid;

   logic [15:0] pressed;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int strobe_cnt = 0;
   int ev_pulses = 0;
   int t_strobe = 0;
   int pend = 0;
   int m_val = 0;
   int m_cnt = 0;

   int exp_code_q[$];
   int exp_val_q[$];
   int exp_cnt_q[$];
   int exp_ent_q[$];

   keypad_entry #(
      .SCAN_DIV     (SD),
      .DEBOUNCE_CNT (DC)
   ) dut (
      .clk_100mhz  (clk_100mhz),
      .reset       (reset),
      .col_n       (col_n),
      .row_n       (row_n),
      .key_strobe  (key_strobe),
      .key_code    (key_code),
      .value       (value),
      .digit_count (digit_count),
      .entry_value (entry_value),
      .entry_valid (entry_valid)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   always @(posedge clk_100mhz) cyc++;

   // Pressed key at (r,c) pulls row r low while column c is driven low.
   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
   end

   task automatic check(input string tag, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int key_pos(input int code);
      case (code)
         1: return 0;   2: return 1;   3: return 2;   10: return 3;
         4: return 4;   5: return 5;   6: return 6;   11: return 7;
         7: return 8;   8: return 9;   9: return 10;  12: return 11;
         14: return 12; 0: return 13;  15: return 14; default: return 15;
      endcase
   endfunction

   task automatic model_key(input int code);
      exp_code_q.push_back(code);
      if (code <= 9) begin
         if (m_cnt < 4) begin
            m_val = m_val * 10 + code;
            m_cnt++;
         end
      end else if (code == 14) begin
         m_val = 0;
         m_cnt = 0;
      end else if (code == 15) begin
         if (m_cnt > 0) begin
            exp_ent_q.push_back(m_val);
            m_val = 0;
            m_cnt = 0;
         end
      end
`ifdef KEYPAD_BACKSPACE_EN
      else if (code == 13) begin
         if (m_cnt > 0) begin
            m_val = m_val / 10;
            m_cnt--;
         end
      end
`endif
      exp_val_q.push_back(m_val);
      exp_cnt_q.push_back(m_cnt);
   endtask

   // Returns at the negedge in the first cycle of column 0.
   task automatic wait_scan_start();
      int n = 0;
      while (col_n !== 4'b0111 && n < 64) begin
         @(negedge clk_100mhz);
         n++;
      end
      while (col_n !== 4'b1110 && n < 64) begin
         @(negedge clk_100mhz);
         n++;
      end
      if (n >= 64) check("scan_align_timeout", n, 0);
   endtask

   task automatic press(input int code, input int hold, input int rel);
      wait_scan_start();
      pressed[key_pos(code)] = 1'b1;
      model_key(code);
      repeat (hold * SCAN) @(negedge clk_100mhz);
      pressed = '0;
      repeat (rel * SCAN) @(negedge clk_100mhz);
   endtask

   always @(negedge clk_100mhz) begin
      if (pend != 0) begin
         pend = 0;
         if (exp_val_q.size() > 0) begin
            check("value", int'(value), exp_val_q.pop_front());
            check("digit_count", int'(digit_count), exp_cnt_q.pop_front());
         end
      end
      if (entry_valid) begin
         ev_pulses++;
         check("entry_expected", int'(exp_ent_q.size() != 0), 1);
         if (exp_ent_q.size() > 0)
            check("entry_value", int'(entry_value), exp_ent_q.pop_front());
      end
      if (key_strobe) begin
         strobe_cnt++;
         t_strobe = cyc;
         check("strobe_expected", int'(exp_code_q.size() != 0), 1);
         if (exp_code_q.size() > 0) begin
            check("key_code", int'(key_code), exp_code_q.pop_front());
            pend = 1;
         end
      end
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_col_n"}, int'(col_n), 14);
      check({tag, "_key_strobe"}, int'(key_strobe), 0);
      check({tag, "_key_code"}, int'(key_code), 0);
      check({tag, "_value"}, int'(value), 0);
      check({tag, "_digit_count"}, int'(digit_count), 0);
      check({tag, "_entry_value"}, int'(entry_value), 0);
      check({tag, "_entry_valid"}, int'(entry_valid), 0);
   endtask

   initial begin
      int s0;
      int e0;
      int t_hold;
      int p7;
      reset   = 1'b1;
      pressed = '0;
      repeat (3) @(negedge clk_100mhz);
      check_reset_state("rst");
      reset = 1'b0;

      // Long hold gives a single strobe, no auto-repeat.
      s0 = strobe_cnt;
      press(5, 12, 4);
      check("hold5_strobes", strobe_cnt - s0, 1);
      check("hold5_value", int'(value), 5);
      check("hold5_count", int'(digit_count), 1);

      // 1234# commits 1234.
      press(14, 4, 4);
      e0 = ev_pulses;
      press(1, 4, 4);
      press(2, 4, 4);
      press(3, 4, 4);
      press(4, 4, 4);
      press(15, 4, 4);
      check("commit_pulses", ev_pulses - e0, 1);
      check("commit_entry", int'(entry_value), 1234);
      check("commit_value", int'(value), 0);

      // Fifth digit ignored, '*' clears, '#' on empty does nothing.
      press(1, 4, 4);
      press(2, 4, 4);
      press(3, 4, 4);
      press(4, 4, 4);
      press(5, 4, 4);
      check("full_value", int'(value), 1234);
      check("full_count", int'(digit_count), 4);
      press(14, 4, 4);
      check("star_value", int'(value), 0);
      e0 = ev_pulses;
      press(15, 4, 4);
      check("empty_hash_pulses", ev_pulses - e0, 0);

      // Bouncy 7, then a stable hold: strobe three scans into the hold.
      s0 = strobe_cnt;
      p7 = key_pos(7);
      wait_scan_start();
      for (int i = 0; i < 4; i++) begin
         pressed[p7] = (i % 2 == 0);
         repeat (SCAN) @(negedge clk_100mhz);
      end
      pressed[p7] = 1'b1;
      model_key(7);
      t_hold = cyc;
      repeat (5 * SCAN) @(negedge clk_100mhz);
      pressed = '0;
      repeat (4 * SCAN) @(negedge clk_100mhz);
      check("toggle_strobes", strobe_cnt - s0, 1);
      check("toggle_latency_ok",
            int'((t_strobe - t_hold) >= 3 * SCAN - 1 &&
                 (t_strobe - t_hold) <= 3 * SCAN + 1), 1);

      // Two keys at once ghost to nothing; releasing one accepts the other.
      s0 = strobe_cnt;
      wait_scan_start();
      pressed[key_pos(1)] = 1'b1;
      pressed[key_pos(2)] = 1'b1;
      repeat (6 * SCAN) @(negedge clk_100mhz);
      check("ghost_strobes", strobe_cnt - s0, 0);
      pressed[key_pos(2)] = 1'b0;
      model_key(1);
      repeat (4 * SCAN) @(negedge clk_100mhz);
      pressed = '0;
      repeat (4 * SCAN) @(negedge clk_100mhz);
      check("ghost_release_strobes", strobe_cnt - s0, 1);

      // 'D' is backspace only when the option is built in.
      press(14, 4, 4);
      press(1, 4, 4);
      press(2, 4, 4);
      press(3, 4, 4);
      press(13, 4, 4);
`ifdef KEYPAD_BACKSPACE_EN
      check("d_value", int'(value), 12);
      check("d_count", int'(digit_count), 2);
`else
      check("d_value", int'(value), 123);
      check("d_count", int'(digit_count), 3);
`endif

      // Reset in the middle of a scan and an entry.
      press(14, 4, 4);
      press(1, 4, 4);
      press(2, 4, 4);
      wait_scan_start();
      pressed[key_pos(3)] = 1'b1;
      repeat (SCAN + 6) @(negedge clk_100mhz);
      reset = 1'b1;
      repeat (3) @(negedge clk_100mhz);
      check_reset_state("midrst");
      pressed = '0;
      pend    = 0;
      m_val   = 0;
      m_cnt   = 0;
      exp_code_q.delete();
      exp_val_q.delete();
      exp_cnt_q.delete();
      exp_ent_q.delete();
      reset = 1'b0;
      press(4, 4, 4);
      check("post_rst_value", int'(value), 4);
      check("post_rst_count", int'(digit_count), 1);

      repeat (4) @(negedge clk_100mhz);
      check("leftover_codes", exp_code_q.size(), 0);
      check("leftover_entries", exp_ent_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
